// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux
//
// Multiplexed seven-segment display driver for NUM_DIGITS digits.
// A value is loaded with WE, either as raw hex nibbles or as an unsigned
// binary number that is converted to decimal by an iterative double-dabble
// engine (one bit per cycle, W = 4*NUM_DIGITS cycles). Leading zero digits can
// be blanked, and a decimal value that does not fit shows dashes on every digit
// and raises overflow. The digits are scanned one at a time, each one staying
// selected for REFRESH_DIV cycles.
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   synchronous, active-high reset
//   WE          in   load strobe (accepted only while busy = 0)
//   WDATA       in   [W-1:0] value to display
//   DEC_MODE    in   0 = hex nibbles, 1 = unsigned binary shown in decimal
//   BLANK_LZ    in   1 = blank leading zero digits (digit 0 never blanked)
//   busy        out  decimal conversion in progress
//   overflow    out  last decimal load exceeded 10^NUM_DIGITS-1
//   digit_sel   out  [NUM_DIGITS-1:0] one-hot digit enable, bit 0 = LSD
//   seg_pins_n  out  [6:0] active-low segments {g,f,e,d,c,b,a}
//
// Handshake: a load is accepted on a rising edge where WE=1 and busy=0
// (busy sampled before the edge). WE while busy is dropped, never queued.
// -----------------------------------------------------------------------------
module seg_display_mux #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    WE,
    input  logic [4*NUM_DIGITS-1:0] WDATA,
    input  logic                    DEC_MODE,
    input  logic                    BLANK_LZ,
    output logic                    busy,
    output logic                    overflow,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg_pins_n
);

    localparam int W      = 4 * NUM_DIGITS;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CONV_W = $clog2(W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Largest value representable in NUM_DIGITS decimal digits.
    function automatic logic [63:0] dec_max_f(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] DEC_MAX = dec_max_f(NUM_DIGITS);

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] c);
        case (c)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0010000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Digit i (i > 0) is blanked when nibbles i..NUM_DIGITS-1 are all zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [W-1:0] v,
                                                      input logic       en);
        logic zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (v[4*i +: 4] == 4'd0);
            lz_mask[i] = en & zero_run;
        end
    endfunction

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    // Conversion engine
    state_t                         state_q, state_d;
    logic [CONV_W-1:0]              conv_cnt_q, conv_cnt_d;
    logic [W-1:0]                   bin_q, bin_d;
    logic [W-1:0]                   bcd_q, bcd_d;
    logic                           ovf_pend_q, ovf_pend_d;
    logic                           blz_q, blz_d;

    // Display register
    logic [NUM_DIGITS-1:0][3:0]     code_q, code_d;
    logic [NUM_DIGITS-1:0]          blank_q, blank_d;
    logic [NUM_DIGITS-1:0]          dash_q, dash_d;
    logic                           overflow_q, overflow_d;

    // Scan
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0]          sel_q, sel_d;
    logic [6:0]                     seg_q, seg_d;

    logic [W-1:0]                   bcd_adj;

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        blz_d      = blz_q;
        code_d     = code_q;
        blank_d    = blank_q;
        dash_d     = dash_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sel_d      = '0;
        seg_d      = SEG_BLANK;
        bcd_adj    = bcd_q;

        // Refresh counter and scan index.
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs follow the current display contents every cycle.
        sel_d[idx_q] = 1'b1;
        if (dash_q[idx_q]) begin
            seg_d = SEG_DASH;
        end else if (blank_q[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = hex_glyph(code_q[idx_q]);
        end

        if (state_q == ST_IDLE) begin
            if (WE) begin
                if (DEC_MODE) begin
                    bin_d      = WDATA;
                    bcd_d      = '0;
                    conv_cnt_d = '0;
                    ovf_pend_d = (64'(WDATA) > DEC_MAX);
                    blz_d      = BLANK_LZ;
                    state_d    = ST_CONVERT;
                end else begin
                    code_d     = WDATA;
                    blank_d    = lz_mask(WDATA, BLANK_LZ);
                    dash_d     = '0;
                    overflow_d = 1'b0;
                end
            end
        end else begin
            // Double-dabble step: add 3 to every BCD digit >= 5, then shift
            // the {BCD, binary} pair left by one.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bcd_q[4*i +: 4] >= 4'd5) begin
                    bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
            end
            {bcd_d, bin_d} = {bcd_adj[W-2:0], bin_q, 1'b0};
            conv_cnt_d     = conv_cnt_q + CONV_W'(1);

            if (conv_cnt_q == CONV_W'(W - 1)) begin
                state_d    = ST_IDLE;
                code_d     = bcd_d;
                overflow_d = ovf_pend_q;
                if (ovf_pend_q) begin
                    dash_d  = '1;
                    blank_d = '0;
                end else begin
                    dash_d  = '0;
                    blank_d = lz_mask(bcd_d, blz_q);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            blz_q      <= 1'b0;
            code_q     <= '0;
            blank_q    <= '1;
            dash_q     <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            blz_q      <= blz_d;
            code_q     <= code_d;
            blank_q    <= blank_d;
            dash_q     <= dash_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign busy       = (state_q == ST_CONVERT);
    assign overflow   = overflow_q;
    assign digit_sel  = sel_q;
    assign seg_pins_n = seg_q;

endmodule
